// File: rtl/dtm_pkg.sv
// Shared TAP state encodings, IR codes and DTMCS field positions for the JTAG DTM.
// Pure declarations; no state.
package dtm_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'hF,
        RUN_TEST_IDLE    = 4'hC,
        SELECT_DR_SCAN   = 4'h7,
        CAPTURE_DR       = 4'h6,
        SHIFT_DR         = 4'h2,
        EXIT1_DR         = 4'h1,
        PAUSE_DR         = 4'h3,
        EXIT2_DR         = 4'h0,
        UPDATE_DR        = 4'h5,
        SELECT_IR_SCAN   = 4'h4,
        CAPTURE_IR       = 4'hE,
        SHIFT_IR         = 4'hA,
        EXIT1_IR         = 4'h9,
        PAUSE_IR         = 4'hB,
        EXIT2_IR         = 4'h8,
        UPDATE_IR        = 4'hD
    } tap_state_e;

    typedef struct packed {
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
    } tap_dec_t;

    typedef enum logic [1:0] {
        SEL_IDCODE,
        SEL_DTMCS,
        SEL_DMI,
        SEL_BYPASS
    } dr_sel_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    localparam int         DTMCS_HARDRESET = 17;
    localparam int         DTMCS_RESET     = 16;
    localparam logic [3:0] DTMCS_VERSION   = 4'h1;

    // Unassigned IR codes all fall back to the 1-bit bypass register.
    function automatic dr_sel_e decode_ir(input logic [4:0] ir);
        dr_sel_e sel;
        case (ir)
            IR_IDCODE: sel = SEL_IDCODE;
            IR_DTMCS:  sel = SEL_DTMCS;
            IR_DMI:    sel = SEL_DMI;
            default:   sel = SEL_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register on rising i_tck plus one-hot state decodes.
// Decodes are combinational from the registered state (zero added latency).
module jtag_tap_fsm
    import dtm_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_reset,
    input  logic       i_tms,
    output tap_state_e o_state,
    output tap_dec_t   o_dec
);

    tap_state_e state_q, state_d;

    always_ff @(posedge i_tck) begin
        if (i_reset) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = TEST_LOGIC_RESET;
        case (state_q)
            TEST_LOGIC_RESET: state_d = i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = i_tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = i_tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = i_tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = i_tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = i_tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = i_tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = i_tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = i_tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = i_tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = i_tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = i_tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = i_tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        o_state          = state_q;
        o_dec            = '0;
        o_dec.capture_dr = (state_q == CAPTURE_DR);
        o_dec.shift_dr   = (state_q == SHIFT_DR);
        o_dec.update_dr  = (state_q == UPDATE_DR);
        o_dec.capture_ir = (state_q == CAPTURE_IR);
        o_dec.shift_ir   = (state_q == SHIFT_IR);
        o_dec.update_ir  = (state_q == UPDATE_IR);
    end

endmodule

// File: rtl/jtag_dtm_tap.sv
// JTAG DTM front end: IR, IDCODE/DTMCS/BYPASS DRs, DMI strobes and the falling-edge TDO path.
// DMI strobes are same-cycle decodes; DTMCS reset pulses appear the cycle after UPDATE_DR.
module jtag_dtm_tap
    import dtm_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h1000_0CFD,
    parameter int unsigned ABITS       = 7,
    parameter logic [2:0]  IDLE_CYCLES = 3'd1
) (
    input  logic       i_tck,
    input  logic       i_reset,
    input  logic       i_tms,
    input  logic       i_tdi,
    output logic       o_tdo,
    output logic       o_tdo_en,
    output logic       o_dmi_capture,
    output logic       o_dmi_shift,
    output logic       o_dmi_update,
    output logic       o_dmi_tdi,
    input  logic       i_dmi_tdo,
    output logic       o_dmi_reset,
    output logic       o_dmi_clear_sticky,
    input  logic [1:0] i_dmistat
);

    tap_state_e state;
    tap_dec_t   dec;

    jtag_tap_fsm u_fsm (
        .i_tck   (i_tck),
        .i_reset (i_reset),
        .i_tms   (i_tms),
        .o_state (state),
        .o_dec   (dec)
    );

    logic [4:0]  ir_shift_q, ir_shift_d;
    logic [4:0]  ir_q, ir_d;
    logic [31:0] dr_q, dr_d;
    logic        bypass_q, bypass_d;
    logic        hardreset_q, hardreset_d;
    logic        clr_sticky_q, clr_sticky_d;
    logic        tdo_int_q, sel_dmi_q, tdo_en_q;
    logic        dr_bit0;
    logic        tlr;
    dr_sel_e     dr_sel;
    logic [31:0] dtmcs_cap;

    assign tlr       = (state == TEST_LOGIC_RESET);
    assign dr_sel    = decode_ir(ir_q);
    assign dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_CYCLES, i_dmistat, 6'(ABITS), DTMCS_VERSION};

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        if (dec.capture_ir) begin
            ir_shift_d = 5'b00001;
        end else if (dec.shift_ir) begin
            ir_shift_d = {i_tdi, ir_shift_q[4:1]};
        end
        if (tlr) begin
            ir_d = IR_IDCODE;
        end else if (dec.update_ir) begin
            ir_d = ir_shift_q;
        end
    end

    // The DMI data register lives outside; only IDCODE/DTMCS/BYPASS are held here.
    always_comb begin
        dr_d     = dr_q;
        bypass_d = bypass_q;
        if (dec.capture_dr) begin
            case (dr_sel)
                SEL_IDCODE: dr_d     = IDCODE;
                SEL_DTMCS:  dr_d     = dtmcs_cap;
                SEL_BYPASS: bypass_d = 1'b0;
                default:    ;
            endcase
        end else if (dec.shift_dr) begin
            case (dr_sel)
                SEL_IDCODE, SEL_DTMCS: dr_d     = {i_tdi, dr_q[31:1]};
                SEL_BYPASS:            bypass_d = i_tdi;
                default:               ;
            endcase
        end
    end

    always_comb begin
        hardreset_d  = 1'b0;
        clr_sticky_d = 1'b0;
        if (dec.update_dr && (dr_sel == SEL_DTMCS)) begin
            hardreset_d  = dr_q[DTMCS_HARDRESET];
            clr_sticky_d = dr_q[DTMCS_RESET];
        end
    end

    always_ff @(posedge i_tck) begin
        if (i_reset) begin
            ir_shift_q   <= '0;
            ir_q         <= IR_IDCODE;
            dr_q         <= '0;
            bypass_q     <= 1'b0;
            hardreset_q  <= 1'b0;
            clr_sticky_q <= 1'b0;
        end else begin
            ir_shift_q   <= ir_shift_d;
            ir_q         <= ir_d;
            dr_q         <= dr_d;
            bypass_q     <= bypass_d;
            hardreset_q  <= hardreset_d;
            clr_sticky_q <= clr_sticky_d;
        end
    end

    always_comb begin
        case (dr_sel)
            SEL_BYPASS: dr_bit0 = bypass_q;
            SEL_DMI:    dr_bit0 = 1'b0;
            default:    dr_bit0 = dr_q[0];
        endcase
    end

    // TDO launches on the falling edge so the probe samples it stably on the next rising edge.
    always_ff @(negedge i_tck) begin
        if (i_reset) begin
            tdo_int_q <= 1'b0;
            sel_dmi_q <= 1'b0;
            tdo_en_q  <= 1'b0;
        end else begin
            tdo_int_q <= dec.shift_ir ? ir_shift_q[0] : dr_bit0;
            sel_dmi_q <= dec.shift_dr && (dr_sel == SEL_DMI);
            tdo_en_q  <= dec.shift_ir || dec.shift_dr;
        end
    end

    assign o_tdo              = sel_dmi_q ? i_dmi_tdo : tdo_int_q;
    assign o_tdo_en           = tdo_en_q;
    assign o_dmi_tdi          = i_tdi;
    assign o_dmi_capture      = dec.capture_dr && (dr_sel == SEL_DMI);
    assign o_dmi_shift        = dec.shift_dr   && (dr_sel == SEL_DMI);
    assign o_dmi_update       = dec.update_dr  && (dr_sel == SEL_DMI);
    assign o_dmi_reset        = hardreset_q || tlr;
    assign o_dmi_clear_sticky = clr_sticky_q;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Self-checking bench for jtag_dtm_tap: scripted TAP walks with random data against a
// shift-register-level reference of what each DR/IR must emit.
module tb_jtag_dtm_tap;

    localparam logic [31:0] IDC = 32'h1000_0CFD;

    logic       i_tck = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_tms = 1'b1;
    logic       i_tdi = 1'b0;
    logic       i_dmi_tdo = 1'b0;
    logic [1:0] i_dmistat = 2'b00;
    logic       o_tdo, o_tdo_en, o_dmi_capture, o_dmi_shift, o_dmi_update;
    logic       o_dmi_tdi, o_dmi_reset, o_dmi_clear_sticky;

    jtag_dtm_tap dut (
        .i_tck              (i_tck),
        .i_reset            (i_reset),
        .i_tms              (i_tms),
        .i_tdi              (i_tdi),
        .o_tdo              (o_tdo),
        .o_tdo_en           (o_tdo_en),
        .o_dmi_capture      (o_dmi_capture),
        .o_dmi_shift        (o_dmi_shift),
        .o_dmi_update       (o_dmi_update),
        .o_dmi_tdi          (o_dmi_tdi),
        .i_dmi_tdo          (i_dmi_tdo),
        .o_dmi_reset        (o_dmi_reset),
        .o_dmi_clear_sticky (o_dmi_clear_sticky),
        .i_dmistat          (i_dmistat)
    );

    always #5 i_tck = ~i_tck;

    int   n_vec = 0;
    int   n_err = 0;
    int   cnt_cap, cnt_shift, cnt_upd, cnt_en, mirror_bad, multi_bad, tdi_bad;
    bit   dmi_mode = 1'b0;
    logic tdo_q[$];

    // Output bit i of a capture-then-shift of an L-bit register loaded with cap.
    function automatic logic model_bit(input logic [63:0] cap, input int len,
                                       input logic [63:0] tdi, input int i);
        logic [63:0] c;
        c = cap >> i;
        if (i < len) return c[0];
        c = tdi >> (i - len);
        return c[0];
    endfunction

    function automatic logic [31:0] dtmcs_model(input logic [1:0] stat);
        return (32'd1 << 12) + (32'(stat) << 10) + (32'd7 << 4) + 32'd1;
    endfunction

    task automatic clear_counts();
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0; cnt_en = 0;
        mirror_bad = 0; multi_bad = 0; tdi_bad = 0;
        tdo_q.delete();
    endtask

    // Drive one TCK with the given TMS/TDI, then observe just after the following falling edge.
    task automatic step(input logic tms, input logic tdi);
        i_tms = tms;
        i_tdi = tdi;
        i_dmi_tdo = 1'($urandom);
        @(posedge i_tck);
        @(negedge i_tck);
        #1;
        if (o_dmi_tdi !== i_tdi) tdi_bad++;
        if (o_tdo_en) begin
            tdo_q.push_back(o_tdo);
            cnt_en++;
            if (dmi_mode && (o_tdo !== i_dmi_tdo)) mirror_bad++;
        end
        cnt_cap   += int'(o_dmi_capture);
        cnt_shift += int'(o_dmi_shift);
        cnt_upd   += int'(o_dmi_update);
        if (int'(o_dmi_capture) + int'(o_dmi_shift) + int'(o_dmi_update) > 1) multi_bad++;
    endtask

    task automatic go_shift_dr();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic go_shift_ir();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] bits);
        logic [63:0] b;
        b = bits;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, b[0]);
            b = b >> 1;
        end
    endtask

    task automatic exit_update();
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [4:0] code);
        go_shift_ir();
        shift_bits(5, 64'(code));
        exit_update();
    endtask

    function automatic logic [63:0] q_to_vec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < tdo_q.size() && i < 64; i++) v[i] = tdo_q[i];
        return v;
    endfunction

    task automatic test_reset();
        i_reset = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_vec++;
        if ({o_tdo, o_tdo_en, o_dmi_capture, o_dmi_shift, o_dmi_update, o_dmi_reset, o_dmi_clear_sticky} !== 7'b0000010) begin
            n_err++;
            $display("FAIL reset_outputs: got tdo=%b en=%b cap=%b sh=%b upd=%b rst=%b clr=%b, need 0 0 0 0 0 1 0",
                     o_tdo, o_tdo_en, o_dmi_capture, o_dmi_shift, o_dmi_update, o_dmi_reset, o_dmi_clear_sticky);
        end
        i_reset = 1'b0;
        step(1'b0, 1'b0);
        n_vec++;
        if (o_dmi_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_leave_tlr: o_dmi_reset=%b need 0", o_dmi_reset);
        end
    endtask

    task automatic test_idcode();
        logic [63:0] d;
        clear_counts();
        d = {$urandom, $urandom};
        go_shift_dr();
        shift_bits(32, d);
        n_vec++;
        if (q_to_vec() !== 64'(IDC) || tdo_q.size() != 32) begin
            n_err++;
            $display("FAIL idcode_shift: got %h (%0d bits) need %h (32 bits)", q_to_vec(), tdo_q.size(), IDC);
        end
        exit_update();
        n_vec++;
        if (cnt_en != 32 || cnt_cap + cnt_shift + cnt_upd != 0 || tdi_bad != 0) begin
            n_err++;
            $display("FAIL idcode_en_strobes: en=%0d strobes=%0d tdi_bad=%0d need 32 0 0",
                     cnt_en, cnt_cap + cnt_shift + cnt_upd, tdi_bad);
        end
    endtask

    task automatic test_dtmcs_capture();
        logic [63:0] d, exp_v;
        logic [1:0]  stats [3];
        clear_counts();
        load_ir(5'h10);
        n_vec++;
        if (tdo_q.size() != 5 || q_to_vec() !== 64'h01) begin
            n_err++;
            $display("FAIL ir_capture: got %h (%0d bits) need 01 (5 bits)", q_to_vec(), tdo_q.size());
        end
        stats[0] = 2'b11; stats[1] = 2'b10; stats[2] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            i_dmistat = stats[k];
            clear_counts();
            d = {$urandom, $urandom};
            exp_v = '0;
            for (int i = 0; i < 40; i++) exp_v[i] = model_bit(64'(dtmcs_model(stats[k])), 32, d, i);
            go_shift_dr();
            shift_bits(40, d);
            n_vec++;
            if (q_to_vec() !== exp_v || tdo_q.size() != 40) begin
                n_err++;
                $display("FAIL dtmcs_capture stat=%b: got %h need %h", stats[k], q_to_vec(), exp_v);
            end
            exit_update();
        end
        i_dmistat = 2'b00;
    endtask

    task automatic test_dtmcs_write();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            d[17] = k[1];
            d[16] = k[0];
            go_shift_dr();
            shift_bits(32, 64'(d));
            step(1'b1, 1'b0);
            n_vec++;
            if (o_dmi_reset !== 1'b0 || o_dmi_clear_sticky !== 1'b0) begin
                n_err++;
                $display("FAIL dtmcs_write_early k=%0d: rst=%b clr=%b need 0 0", k, o_dmi_reset, o_dmi_clear_sticky);
            end
            step(1'b0, 1'b0);
            n_vec++;
            if (o_dmi_reset !== k[1] || o_dmi_clear_sticky !== k[0]) begin
                n_err++;
                $display("FAIL dtmcs_write_pulse k=%0d: rst=%b clr=%b need %b %b",
                         k, o_dmi_reset, o_dmi_clear_sticky, k[1], k[0]);
            end
            step(1'b0, 1'b0);
            n_vec++;
            if (o_dmi_reset !== 1'b0 || o_dmi_clear_sticky !== 1'b0) begin
                n_err++;
                $display("FAIL dtmcs_write_width k=%0d: rst=%b clr=%b need 0 0", k, o_dmi_reset, o_dmi_clear_sticky);
            end
        end
        // Capture then straight to update: captured bits 16/17 are zero, so nothing fires.
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        n_vec++;
        if (o_dmi_reset !== 1'b0 || o_dmi_clear_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL dtmcs_zero_shift: rst=%b clr=%b need 0 0", o_dmi_reset, o_dmi_clear_sticky);
        end
    endtask

    task automatic test_bypass();
        logic [4:0]  codes [3];
        logic [63:0] d, exp_v;
        codes[0] = 5'h00; codes[1] = 5'h1F;
        do codes[2] = 5'($urandom); while (codes[2] == 5'h01 || codes[2] == 5'h10 || codes[2] == 5'h11);
        for (int k = 0; k < 3; k++) begin
            load_ir(codes[k]);
            clear_counts();
            d = {$urandom, $urandom};
            exp_v = '0;
            for (int i = 0; i < 20; i++) exp_v[i] = model_bit(64'h1, 1, d, i) & (i != 0);
            go_shift_dr();
            shift_bits(20, d);
            exit_update();
            n_vec++;
            if (q_to_vec() !== exp_v || tdo_q.size() != 20 || cnt_cap + cnt_shift + cnt_upd != 0) begin
                n_err++;
                $display("FAIL bypass ir=%h: got %h need %h strobes=%0d", codes[k], q_to_vec(), exp_v,
                         cnt_cap + cnt_shift + cnt_upd);
            end
        end
    endtask

    task automatic test_dmi();
        load_ir(5'h11);
        dmi_mode = 1'b1;
        clear_counts();
        go_shift_dr();
        shift_bits(41, {$urandom, $urandom});
        exit_update();
        n_vec++;
        if (cnt_cap != 1 || cnt_shift != 41 || cnt_upd != 1 || cnt_en != 41 || multi_bad != 0) begin
            n_err++;
            $display("FAIL dmi_strobes: cap=%0d shift=%0d upd=%0d en=%0d multi=%0d need 1 41 1 41 0",
                     cnt_cap, cnt_shift, cnt_upd, cnt_en, multi_bad);
        end
        n_vec++;
        if (mirror_bad != 0) begin
            n_err++;
            $display("FAIL dmi_tdo_mirror: %0d bits differ from i_dmi_tdo, need 0", mirror_bad);
        end
        dmi_mode = 1'b0;
    endtask

    task automatic test_dmi_pause();
        int a, before_s, before_e;
        a = $urandom_range(1, 40);
        dmi_mode = 1'b1;
        clear_counts();
        go_shift_dr();
        shift_bits(a, {$urandom, $urandom});
        before_s = cnt_cap + cnt_shift + cnt_upd;
        before_e = cnt_en;
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n_vec++;
        if (cnt_cap + cnt_shift + cnt_upd != before_s || cnt_en != before_e) begin
            n_err++;
            $display("FAIL dmi_pause_quiet: strobes %0d->%0d en %0d->%0d need unchanged",
                     before_s, cnt_cap + cnt_shift + cnt_upd, before_e, cnt_en);
        end
        step(1'b0, 1'b0);
        shift_bits(41 - a, {$urandom, $urandom});
        exit_update();
        n_vec++;
        if (cnt_cap != 1 || cnt_shift != 41 || cnt_upd != 1 || mirror_bad != 0) begin
            n_err++;
            $display("FAIL dmi_pause_total a=%0d: cap=%0d shift=%0d upd=%0d mirror=%0d need 1 41 1 0",
                     a, cnt_cap, cnt_shift, cnt_upd, mirror_bad);
        end
        dmi_mode = 1'b0;
    endtask

    task automatic test_tms_reset();
        int walk;
        go_shift_ir();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        n_vec++;
        if (o_dmi_reset !== 1'b0) begin
            n_err++;
            $display("FAIL tms_four_ones: o_dmi_reset=%b need 0", o_dmi_reset);
        end
        step(1'b1, 1'b0);
        n_vec++;
        if (o_dmi_reset !== 1'b1) begin
            n_err++;
            $display("FAIL tms_five_ones: o_dmi_reset=%b need 1", o_dmi_reset);
        end
        step(1'b0, 1'b0);
        clear_counts();
        go_shift_dr();
        shift_bits(32, {$urandom, $urandom});
        exit_update();
        n_vec++;
        if (q_to_vec() !== 64'(IDC)) begin
            n_err++;
            $display("FAIL tlr_ir_idcode: got %h need %h", q_to_vec(), IDC);
        end
        for (int r = 0; r < 6; r++) begin
            walk = $urandom_range(0, 12);
            for (int i = 0; i < walk; i++) step(1'($urandom), 1'($urandom));
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
            n_vec++;
            if (o_dmi_reset !== 1'b1) begin
                n_err++;
                $display("FAIL tms_any_state walk=%0d: o_dmi_reset=%b need 1", walk, o_dmi_reset);
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_in_shift();
        load_ir(5'h11);
        clear_counts();
        go_shift_dr();
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        i_reset = 1'b1;
        step(1'b0, 1'b0);
        i_reset = 1'b0;
        n_vec++;
        if (o_dmi_reset !== 1'b1 || o_dmi_update !== 1'b0 || o_dmi_shift !== 1'b0 || o_tdo_en !== 1'b0 || cnt_upd != 0) begin
            n_err++;
            $display("FAIL reset_in_shift: rst=%b upd=%b sh=%b en=%b upd_cnt=%0d need 1 0 0 0 0",
                     o_dmi_reset, o_dmi_update, o_dmi_shift, o_tdo_en, cnt_upd);
        end
        step(1'b0, 1'b0);
        clear_counts();
        go_shift_dr();
        shift_bits(32, {$urandom, $urandom});
        exit_update();
        n_vec++;
        if (q_to_vec() !== 64'(IDC) || cnt_upd != 0) begin
            n_err++;
            $display("FAIL reset_ir_idcode: got %h upd=%0d need %h 0", q_to_vec(), cnt_upd, IDC);
        end
        // Reset landing on the UPDATE_DR edge must drop the pending DTMCS pulses.
        load_ir(5'h10);
        go_shift_dr();
        shift_bits(32, 64'h0003_0000);
        step(1'b1, 1'b0);
        i_reset = 1'b1;
        step(1'b0, 1'b0);
        i_reset = 1'b0;
        n_vec++;
        if (o_dmi_clear_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drops_pulse: clr=%b need 0", o_dmi_clear_sticky);
        end
        step(1'b0, 1'b0);
        n_vec++;
        if (o_dmi_clear_sticky !== 1'b0 || o_dmi_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_pulse: clr=%b rst=%b need 0 0", o_dmi_clear_sticky, o_dmi_reset);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge i_tck);
        #1;
        test_reset();
        test_idcode();
        test_dtmcs_capture();
        test_dtmcs_write();
        test_bypass();
        test_dmi();
        test_dmi_pause();
        test_tms_reset();
        test_reset_in_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_dtm_tap.md
Name: jtag_dtm_tap

Overview:
JTAG TAP controller and Debug Transport Module front end that sequences the DMI shift register.
- Runs the IEEE 1149.1 16-state TAP FSM from TMS.
- Owns the IR, IDCODE, DTMCS and BYPASS registers.
- Drives the DMI register's capture/shift/update strobes when IR selects DMI.
- Converts DTMCS dmireset/dmihardreset writes into the DMI block's clear-sticky/reset inputs.

Parameters:
IDCODE, 32'h1000_0CFD, value captured into the IDCODE DR; bit0 must be 1.
ABITS, 7, DMI address width reported in dtmcs.abits.
IDLE_CYCLES, 3'd1, value reported in dtmcs.idle.

Ports:
i_tck  in  1  JTAG clock; the only clock.
i_reset  in  1  synchronous, active-high reset.
i_tms  in  1  test mode select.
i_tdi  in  1  test data in.
o_tdo  out  1  test data out, changes on falling i_tck.
o_tdo_en  out  1  high while in SHIFT_IR/SHIFT_DR (pad output enable).
o_dmi_capture  out  1  DMI capture strobe.
o_dmi_shift  out  1  DMI shift strobe.
o_dmi_update  out  1  DMI update strobe.
o_dmi_tdi  out  1  serial data to DMI register.
i_dmi_tdo  in  1  serial data from DMI register, already falling-edge registered.
o_dmi_reset  out  1  DMI hard reset.
o_dmi_clear_sticky  out  1  DMI sticky-error clear.
i_dmistat  in  2  DMI status (0 ok, 2 failed, 3 busy) reported in dtmcs.

Behaviour:
- Clock and reset: single clock i_tck; reset synchronous, active-high on i_reset.
- FSM update:
  - TAP state register updates on rising i_tck per the 1149.1 TMS graph.
  - i_reset forces TEST_LOGIC_RESET.
  - Five consecutive TMS=1 clocks reach TEST_LOGIC_RESET from any state.
- IR (5 bits):
  - CAPTURE_IR loads 5'b00001.
  - SHIFT_IR shifts right, i_tdi entering bit4.
  - UPDATE_IR latches into the active IR.
  - Active IR is 5'h01 (IDCODE) in TEST_LOGIC_RESET and on i_reset.
- IR decode:
  - 5'h01 = IDCODE.
  - 5'h10 = DTMCS.
  - 5'h11 = DMI.
  - Any other code, including 5'h00 and 5'h1F, = BYPASS (1-bit, captures 0).
- DR shifting:
  - Shift is LSB first.
  - IDCODE and DTMCS shift registers are 32 bits; i_tdi enters bit31.
  - CAPTURE_DR loads the selected register.
- DTMCS capture value: {14'b0, 1'b0, 1'b0, 1'b0, IDLE_CYCLES, i_dmistat, ABITS[5:0], 4'h1}, i.e. version = 1.
- DTMCS write: on UPDATE_DR with IR=DTMCS:
  - shifted bit17 = 1 → o_dmi_reset high for exactly the next cycle.
  - shifted bit16 = 1 → o_dmi_clear_sticky high for exactly the next cycle.
  - Both bits set → both pulses in the same cycle.
  - All other bits are ignored.
- o_dmi_reset is also high combinationally whenever the state is TEST_LOGIC_RESET.
- DMI strobes are combinational decodes of the registered state ANDed with IR==DMI:
  - o_dmi_capture = CAPTURE_DR.
  - o_dmi_shift = SHIFT_DR.
  - o_dmi_update = UPDATE_DR.
  - Exactly one strobe is high at a time; none are high when IR≠DMI.
  - The DMI acts on the rising edge ending that state, so capture-to-shift latency is zero extra cycles.
- o_dmi_tdi = i_tdi (wire).
- TDO path:
  - On falling i_tck, register tdo_int: ir_shift[0] in SHIFT_IR, otherwise the selected DR bit0.
  - On the same falling edge, register sel_dmi_q = (state==SHIFT_DR && IR==DMI).
  - o_tdo = sel_dmi_q ? i_dmi_tdo : tdo_int.
  - o_tdo_en is registered on falling i_tck from (SHIFT_IR|SHIFT_DR).
- Reset values:
  - Outputs: o_tdo=0, o_tdo_en=0, o_dmi_capture/shift/update=0, o_dmi_reset=1 (state is TLR), o_dmi_clear_sticky=0.
  - Internal: pulse registers 0; shift registers 0.
- Boundary cases:
  - i_reset during SHIFT_DR: the shift is abandoned, no update strobe, and a DTMCS pulse pending from the prior cycle is cleared.
  - EXIT1_DR→UPDATE_DR with zero shifts: update uses the captured value. DTMCS bits16/17 capture as 0, so no pulse.
  - PAUSE_DR and EXIT2_DR hold all shift registers and assert no strobes.

Decomposition:
- Package dtm_pkg:
  - tap_state_e, a 16-entry enum with 1149.1 encodings.
  - IR codes IR_IDCODE, IR_DTMCS, IR_DMI, IR_BYPASS.
  - DTMCS field bit constants: DTMCS_HARDRESET=17, DTMCS_RESET=16, version value.
- Sub-module jtag_tap_fsm: contains the state register and next-state logic (inputs i_tck, i_reset, i_tms; outputs state plus one-hot decodes).
- jtag_dtm_tap contains the IR, the DRs and the TDO mux.

Test Plan:
- i_reset, then TMS to SHIFT_DR, shift 32 bits → o_tdo yields 32'h1000_0CFD LSB first; o_tdo_en=1 for exactly 32 falling edges.
- Load IR=5'h10, capture DTMCS with i_dmistat=2'b11 → shifted value 32'h0000_1C71.
- With IR=DTMCS, shift 32'h0001_0000 and UPDATE_DR → o_dmi_clear_sticky=1 for one cycle, o_dmi_reset=0. Repeat with 32'h0002_0000 → o_dmi_reset one-cycle pulse.
- With IR=5'h11, run CAPTURE→41×SHIFT→UPDATE → exactly one o_dmi_capture cycle, 41 o_dmi_shift cycles, one o_dmi_update cycle. o_tdo mirrors i_dmi_tdo during shift.
- With IR=5'h11 and a 3-cycle PAUSE_DR mid-shift → no strobes during PAUSE/EXIT2; shift count is still 41.
- From SHIFT_IR, hold TMS=1 for 5 clocks → TEST_LOGIC_RESET, IR=5'h01, o_dmi_reset=1. Assert i_reset in SHIFT_DR → next cycle state TLR with no o_dmi_update.
